// File: rtl/sum_acc_if.sv
// sum_acc_if: stream handshake bundle for the sum_acc accumulator.
// master drives input words and takes results; slave is the accumulator side.
interface sum_acc_if #(
   parameter int unsigned BUS_WIDTH   = 32,
   parameter int unsigned CARRY_WIDTH = 8
);
   logic                   acc_in_valid;
   logic                   acc_in_ready;
   logic [BUS_WIDTH-1:0]   acc_in_data;
   logic                   acc_in_last;
   logic                   acc_out_valid;
   logic                   acc_out_ready;
   logic [BUS_WIDTH-1:0]   acc_out_data;
   logic [CARRY_WIDTH-1:0] acc_out_carry;
   logic                   acc_out_ovf;

   modport master (
      output acc_in_valid, acc_in_data, acc_in_last, acc_out_ready,
      input  acc_in_ready, acc_out_valid, acc_out_data, acc_out_carry, acc_out_ovf
   );

   modport slave (
      input  acc_in_valid, acc_in_data, acc_in_last, acc_out_ready,
      output acc_in_ready, acc_out_valid, acc_out_data, acc_out_carry, acc_out_ovf
   );
endinterface

// File: rtl/sum_acc.sv
// sum_acc: packet accumulator around the combinational ripple adder `sum`.
// Adds each accepted word into a running total, counts MSB carries with a
// saturating counter, and holds the packet result until downstream takes it.
// Optional feature: define SUM_ACC_OVERLAP_EN to accept the first word of the
// next packet on the same edge the current result is taken.

// sum: combinational BUS_WIDTH ripple-carry adder.
module sum #(
   parameter int unsigned BUS_WIDTH = 32
) (
   input  logic [BUS_WIDTH-1:0] sum_in1,
   input  logic [BUS_WIDTH-1:0] sum_in2,
   output logic [BUS_WIDTH-1:0] sum_out,
   output logic                 sum_nextbit_out
);
   logic [BUS_WIDTH:0] chain;

   // ripple the carry from bit 0 up through the MSB
   always_comb begin
      chain   = '0;
      sum_out = '0;
      for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
         sum_out[i]   = sum_in1[i] ^ sum_in2[i] ^ chain[i];
         chain[i + 1] = (sum_in1[i] & sum_in2[i]) | (chain[i] & (sum_in1[i] ^ sum_in2[i]));
      end
      sum_nextbit_out = chain[BUS_WIDTH];
   end
endmodule

module sum_acc #(
   parameter int unsigned BUS_WIDTH   = 32,
   parameter int unsigned CARRY_WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   sum_acc_if.slave acc
);
   typedef enum logic {ACC, OUT} state_t;

   state_t                 state, state_next;
   logic [BUS_WIDTH-1:0]   total, total_next;
   logic [CARRY_WIDTH-1:0] carry, carry_next;
   logic                   ovf, ovf_next;
   logic [BUS_WIDTH-1:0]   add_out;
   logic                   add_carry;
   logic                   in_ready;
   logic                   out_valid;
   logic                   accept;
   logic                   taken;

   sum #(.BUS_WIDTH(BUS_WIDTH)) u_sum (
      .sum_in1         (total),
      .sum_in2         (acc.acc_in_data),
      .sum_out         (add_out),
      .sum_nextbit_out (add_carry)
   );

   // handshake qualifiers; in_ready depends on state (and out_ready under overlap) only
   always_comb begin
      out_valid = (state == OUT);
`ifdef SUM_ACC_OVERLAP_EN
      in_ready  = (state == ACC) ? 1'b1 : acc.acc_out_ready;
`else
      in_ready  = (state == ACC);
`endif
      accept    = acc.acc_in_valid & in_ready;
      taken     = out_valid & acc.acc_out_ready;
   end

   // next-state and datapath update
   always_comb begin
      state_next = state;
      total_next = total;
      carry_next = carry;
      ovf_next   = ovf;
      case (state)
         ACC: begin
            if (accept) begin
               total_next = add_out;
               if (add_carry) begin
                  if (carry == '1) begin
                     ovf_next = 1'b1;
                  end else begin
                     carry_next = carry + CARRY_WIDTH'(1);
                  end
               end
               if (acc.acc_in_last) begin
                  state_next = OUT;
               end
            end
         end
         OUT: begin
            if (taken) begin
               total_next = '0;
               carry_next = '0;
               ovf_next   = 1'b0;
               state_next = ACC;
`ifdef SUM_ACC_OVERLAP_EN
               // a word on the handshake edge starts from zero, so data alone is the
               // new total and it cannot carry; bypassing the adder keeps it on `total`
               if (accept) begin
                  total_next = acc.acc_in_data;
                  if (acc.acc_in_last) begin
                     state_next = OUT;
                  end
               end
`endif
            end
         end
         default: state_next = ACC;
      endcase
   end

   // state and result registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACC;
         total <= '0;
         carry <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         total <= total_next;
         carry <= carry_next;
         ovf   <= ovf_next;
      end
   end

   assign acc.acc_in_ready  = in_ready;
   assign acc.acc_out_valid = out_valid;
   assign acc.acc_out_data  = total;
   assign acc.acc_out_carry = carry;
   assign acc.acc_out_ovf   = ovf;
endmodule

// File: doc/sum_acc.md
# sum_acc

Sequential accumulator wrapped around the existing combinational `BUS_WIDTH` ripple adder (`sum`). It takes a valid/ready stream of `BUS_WIDTH` words, adds each accepted word into a running total, and counts the carries out of bit `BUS_WIDTH-1`. On the word flagged last, it presents the packet total and carry count downstream until they are taken. The block instantiates exactly one `sum`: the running total drives `sum_in1`, incoming data drives `sum_in2`, and `sum_out`/`sum_nextbit_out` feed the registers.

## Interface
- `BUS_WIDTH`, 32, width of data words and of the running total.
- `CARRY_WIDTH`, 8, width of the saturating carry counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `acc_in_valid`  in  1  input word valid.
- `acc_in_ready`  out  1  block can accept an input word.
- `acc_in_data`  in  `BUS_WIDTH`  word to add.
- `acc_in_last`  in  1  word is the final word of the packet.
- `acc_out_valid`  out  1  result valid.
- `acc_out_ready`  in  1  downstream accepts the result.
- `acc_out_data`  out  `BUS_WIDTH`  packet sum modulo 2^`BUS_WIDTH`.
- `acc_out_carry`  out  `CARRY_WIDTH`  number of carries out of the MSB during the packet, saturating.
- `acc_out_ovf`  out  1  carry counter saturated during this packet.

## Operation
- States:
  - ACC: `acc_in_ready`=1, `acc_out_valid`=0.
  - OUT: `acc_in_ready`=0 (see Configuration), `acc_out_valid`=1.
- An input beat is accepted when `acc_in_valid`&`acc_in_ready` are both high at a rising edge. On acceptance:
  - total <= `sum_out` (total + data, truncated to `BUS_WIDTH`).
  - If `sum_nextbit_out`=1: carry <= carry+1, unless carry is all-ones. If already all-ones, carry holds and ovf <= 1.
  - If `acc_in_last`=1, go to OUT.
- Accepting a word that would make the count reach all-ones does not set ovf. Only a carry arriving while the count is already all-ones sets ovf.
- In OUT, the outputs show the registered total, carry and ovf, held stable while `acc_out_ready`=0.
- The output handshake is `acc_out_valid`&`acc_out_ready`. On it: total, carry and ovf clear to 0, and the state goes to ACC.
- `acc_in_data` and `acc_in_last` are ignored when `acc_in_valid`=0. Data and last may change freely when the beat is not accepted.
- A single-word packet produces total = data, carry = 0.
- Reset at any time, including mid-packet or in OUT, drops the partial packet. The state goes to ACC with all registers cleared.

## Timing
- Reset values: `acc_in_ready`=1, `acc_out_valid`=0, `acc_out_data`=0, `acc_out_carry`=0, `acc_out_ovf`=0.
- Throughput in ACC: one word per cycle.
- Latency: if the last word is accepted at edge N, `acc_out_valid` is 1 and the outputs are final from edge N.
- Output hold: if the result is taken at edge M, `acc_out_valid` is 0 from edge M.
- Without overlap, the first word of the next packet can be accepted at edge M+1 at the earliest.
- `acc_in_ready` depends on state only (plus `acc_out_ready` under the macro). There are no combinational paths from `acc_in_valid` to `acc_in_ready` or from `acc_out_ready` to `acc_out_valid`.
- The adder path (`sum`) is combinational, registered once inside this block.

## Configuration
- `SUM_ACC_OVERLAP_EN` defined:
  - In OUT, `acc_in_ready` = `acc_out_ready`.
  - A word accepted on the output-handshake edge starts the new packet: total <= data, and carry and ovf start from 0.
  - If that word also has last=1, the state stays OUT with the new result.
  - This gives zero bubble between packets.
- Not defined: `acc_in_ready`=0 for the whole of OUT, so there is a one-cycle bubble after each result.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. Required: outputs at their reset values immediately, `acc_in_ready`=1.
- Basic packet: words 5, 7, 10(last) on consecutive cycles, `acc_out_ready`=1. Required: `acc_out_data`=22, carry=0, ovf=0; `acc_out_valid` for exactly one cycle.
- Carry: words 0xFFFFFFFF, 0x00000002(last). Required: data=0x00000001, carry=1.
- Back-pressure: packet 3, 4(last) with `acc_out_ready`=0 for 5 cycles. Required: data=7 held stable and `acc_in_ready`=0 throughout; accepted on the cycle ready rises.
- Saturation: 300 words of 0xFFFFFFFF, last on the 300th, `CARRY_WIDTH`=8. Required: data=0xFFFFFED4, carry=255, ovf=1. The next packet of 1(last) gives data=1, carry=0, ovf=0.
- Reset mid-packet, then overlap: after words 9, 9, assert `rst`, then send 2(last). Required: data=2. With `SUM_ACC_OVERLAP_EN`, a word 6(last) presented on the handshake cycle gives the next result 6 with no idle cycle.
